// File: rtl/pipeline_control.sv
// Pipeline hazard/stall controller: freezes on data-memory waits, squashes on
// mispredicts, stalls on load-use and fetch waits, and drains the pipe on HLT.
module pipeline_control (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [2:0]  i_inst_type_id,
    input  logic        i_valid_id,
    input  logic [1:0]  i_rs_id,
    input  logic [1:0]  i_rt_id,
    input  logic        i_use_rs_id,
    input  logic        i_use_rt_id,
    input  logic        i_valid_ex,
    input  logic        i_mem_read_ex,
    input  logic [1:0]  i_dest_ex,
    input  logic        i_mispredict_ex,
    input  logic        i_d_req_mem,
    input  logic        i_d_ready,
    input  logic        i_i_ready,
    output logic        o_pc_write,
    output logic        o_ir_write,
    output logic        o_bubblify,
    output logic        o_flush,
    output logic        o_halted,
    output logic [15:0] o_num_inst,
    output logic [15:0] o_stall_cycles
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_MEMWAIT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_HALTED  = 2'd3;

    localparam logic [2:0] INSTTYPE_ALU    = 3'd0;
    localparam logic [2:0] INSTTYPE_LOAD   = 3'd1;
    localparam logic [2:0] INSTTYPE_STORE  = 3'd2;
    localparam logic [2:0] INSTTYPE_BRANCH = 3'd3;
    localparam logic [2:0] INSTTYPE_JUMP   = 3'd4;
    localparam logic [2:0] INSTTYPE_HLT    = 3'd7;

    logic [1:0]  r_state;
    logic [1:0]  r_drain_cnt;
    logic [15:0] r_num_inst;
    logic [15:0] r_stall_cycles;

    logic [1:0]  w_next_state;
    logic [1:0]  w_next_cnt;
    logic        w_pc_write;
    logic        w_ir_write;
    logic        w_bubblify;
    logic        w_flush;
    logic        w_frozen;
    logic        w_jump_sel;
    logic        w_issue;

    logic        w_freeze_req;
    logic        w_mispredict;
    logic        w_load_use;
    logic        w_hlt;
    logic        w_jump;

    assign w_freeze_req = i_d_req_mem & ~i_d_ready;
    assign w_mispredict = i_mispredict_ex & i_valid_ex;
    assign w_load_use   = i_valid_ex & i_mem_read_ex & i_valid_id &
                          ((i_use_rs_id & (i_rs_id == i_dest_ex)) |
                           (i_use_rt_id & (i_rt_id == i_dest_ex)));
    assign w_hlt        = i_valid_id & (i_inst_type_id == INSTTYPE_HLT);
    assign w_jump       = i_valid_id & (i_inst_type_id == INSTTYPE_JUMP);

    // Prioritised control decode and next-state selection
    always_comb begin
        w_pc_write   = 1'b1;
        w_ir_write   = 1'b1;
        w_bubblify   = 1'b0;
        w_flush      = 1'b0;
        w_frozen     = 1'b0;
        w_jump_sel   = 1'b0;
        w_next_state = r_state;
        w_next_cnt   = r_drain_cnt;
        case (r_state)
            S_RUN, S_MEMWAIT: begin
                w_next_state = S_RUN;
                if (w_freeze_req) begin
                    w_pc_write   = 1'b0;
                    w_ir_write   = 1'b0;
                    w_frozen     = 1'b1;
                    w_next_state = S_MEMWAIT;
                end else if (w_mispredict) begin
                    w_bubblify = 1'b1;
                    w_flush    = 1'b1;
                end else if (w_load_use) begin
                    w_pc_write = 1'b0;
                    w_ir_write = 1'b0;
                    w_bubblify = 1'b1;
                end else if (w_hlt) begin
                    w_pc_write   = 1'b0;
                    w_ir_write   = 1'b0;
                    w_bubblify   = 1'b1;
                    w_next_state = S_DRAIN;
                    w_next_cnt   = 2'd3;
                end else if (w_jump) begin
                    w_flush    = 1'b1;
                    w_jump_sel = 1'b1;
                end else if (!i_i_ready) begin
                    w_pc_write = 1'b0;
                    w_ir_write = 1'b0;
                    w_bubblify = 1'b1;
                end else begin
                    w_pc_write = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_freeze_req) begin
                    w_pc_write = 1'b0;
                    w_ir_write = 1'b0;
                    w_frozen   = 1'b1;
                end else if (w_mispredict) begin
                    // HLT sat on a wrong path: abandon the drain
                    w_bubblify   = 1'b1;
                    w_flush      = 1'b1;
                    w_next_state = S_RUN;
                    w_next_cnt   = 2'd0;
                end else begin
                    w_pc_write = 1'b0;
                    w_ir_write = 1'b0;
                    w_bubblify = 1'b1;
                    w_next_cnt = r_drain_cnt - 2'd1;
                    if (r_drain_cnt == 2'd1) begin
                        w_next_state = S_HALTED;
                    end else begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_HALTED: begin
                w_pc_write = 1'b0;
                w_ir_write = 1'b0;
                w_bubblify = 1'b1;
            end
            default: begin
                w_next_state = S_RUN;
                w_next_cnt   = 2'd0;
            end
        endcase
    end

    // A jump's flush discards the fetch-side slot only; the jump itself issues.
    assign w_issue = i_valid_id & ~w_bubblify & ~w_frozen & (~w_flush | w_jump_sel);

    // State, drain counter and statistics registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_RUN;
            r_drain_cnt    <= 2'd0;
            r_num_inst     <= 16'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_cnt;
            if (w_issue) begin
                r_num_inst <= r_num_inst + 16'd1;
            end
            if (!w_pc_write && (r_state != S_HALTED) && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign o_pc_write     = i_reset ? 1'b1 : w_pc_write;
    assign o_ir_write     = i_reset ? 1'b1 : w_ir_write;
    assign o_bubblify     = i_reset ? 1'b0 : w_bubblify;
    assign o_flush        = i_reset ? 1'b0 : w_flush;
    assign o_halted       = ~i_reset & (r_state == S_HALTED);
    assign o_num_inst     = r_num_inst;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: single-cycle vector table plus
// multi-cycle sequences for freeze, drain, abort, reset and counter wrap.
module tb_pipeline_control;

    localparam logic [2:0] T_ALU  = 3'd0;
    localparam logic [2:0] T_JUMP = 3'd4;
    localparam logic [2:0] T_HLT  = 3'd7;

    logic        clk;
    logic        reset;
    logic [2:0]  inst_type_id;
    logic        valid_id, use_rs_id, use_rt_id;
    logic [1:0]  rs_id, rt_id, dest_ex;
    logic        valid_ex, mem_read_ex, mispredict_ex;
    logic        d_req_mem, d_ready, i_ready;
    logic        pc_write, ir_write, bubblify, flush, halted;
    logic [15:0] num_inst, stall_cycles;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_inst;
    logic [15:0] exp_stall;

    typedef struct {
        logic [2:0] ty;
        logic       vid;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       urs;
        logic       urt;
        logic       vex;
        logic       mr;
        logic [1:0] dst;
        logic       mis;
        logic       dreq;
        logic       drdy;
        logic       irdy;
        logic [3:0] exp_ctrl;   // {pc_write, ir_write, bubblify, flush}
        logic       inc_inst;
        logic       inc_stall;
    } vec_t;

    vec_t vecs[16];

    pipeline_control dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_inst_type_id (inst_type_id),
        .i_valid_id     (valid_id),
        .i_rs_id        (rs_id),
        .i_rt_id        (rt_id),
        .i_use_rs_id    (use_rs_id),
        .i_use_rt_id    (use_rt_id),
        .i_valid_ex     (valid_ex),
        .i_mem_read_ex  (mem_read_ex),
        .i_dest_ex      (dest_ex),
        .i_mispredict_ex(mispredict_ex),
        .i_d_req_mem    (d_req_mem),
        .i_d_ready      (d_ready),
        .i_i_ready      (i_ready),
        .o_pc_write     (pc_write),
        .o_ir_write     (ir_write),
        .o_bubblify     (bubblify),
        .o_flush        (flush),
        .o_halted       (halted),
        .o_num_inst     (num_inst),
        .o_stall_cycles (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [2:0] ty, input logic vid, input logic [1:0] rs,
                                input logic [1:0] rt, input logic urs, input logic urt,
                                input logic vex, input logic mr, input logic [1:0] dst,
                                input logic mis, input logic dreq, input logic drdy,
                                input logic irdy, input logic [3:0] ec, input logic ii,
                                input logic is);
        vec_t v;
        v.ty = ty; v.vid = vid; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.vex = vex; v.mr = mr; v.dst = dst; v.mis = mis; v.dreq = dreq;
        v.drdy = drdy; v.irdy = irdy; v.exp_ctrl = ec; v.inc_inst = ii; v.inc_stall = is;
        return v;
    endfunction

    function automatic logic [15:0] ctrl_now();
        return {11'd0, halted, pc_write, ir_write, bubblify, flush};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        inst_type_id = v.ty; valid_id = v.vid; rs_id = v.rs; rt_id = v.rt;
        use_rs_id = v.urs; use_rt_id = v.urt; valid_ex = v.vex; mem_read_ex = v.mr;
        dest_ex = v.dst; mispredict_ex = v.mis; d_req_mem = v.dreq; d_ready = v.drdy;
        i_ready = v.irdy;
    endtask

    task automatic idle(input logic vid);
        apply(mk(T_ALU, vid, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0,
                 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_num_inst"}, num_inst, exp_inst);
        chk({tag, "_stall"}, stall_cycles, exp_stall);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        idle(1'b0);
        #1;
        chk({tag, "_reset_ctrl"}, ctrl_now(), 16'h000C);
        tick();
        reset = 1'b0;
        exp_inst = 16'd0;
        exp_stall = 16'd0;
        check_counters({tag, "_post_reset"});
    endtask

    initial begin
        // idle, plain issue, load-use rs/rt, near-misses, mispredict, jump, fetch wait
        vecs[0]  = mk(T_ALU,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0);
        vecs[1]  = mk(T_ALU,  1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);
        vecs[2]  = mk(T_ALU,  1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1);
        vecs[3]  = mk(T_ALU,  1'b1, 2'd1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1);
        vecs[4]  = mk(T_ALU,  1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);
        vecs[5]  = mk(T_ALU,  1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);
        vecs[6]  = mk(T_ALU,  1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);
        vecs[7]  = mk(T_ALU,  1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        vecs[8]  = mk(T_ALU,  1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);
        vecs[9]  = mk(T_ALU,  1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        vecs[10] = mk(T_JUMP, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0);
        vecs[11] = mk(T_JUMP, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0);
        vecs[12] = mk(T_JUMP, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1);
        vecs[13] = mk(T_ALU,  1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1);
        vecs[14] = mk(T_JUMP, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 1'b1, 1'b0);
        vecs[15] = mk(T_ALU,  1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);

        reset = 1'b1;
        idle(1'b0);
        exp_inst = 16'd0;
        exp_stall = 16'd0;
        tick();
        tick();
        do_reset("init");

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctrl", i), ctrl_now(), {12'd0, vecs[i].exp_ctrl});
            tick();
            exp_inst  = exp_inst + {15'd0, vecs[i].inc_inst};
            exp_stall = exp_stall + {15'd0, vecs[i].inc_stall};
            check_counters($sformatf("vec%0d", i));
        end

        // Freeze dominates load-use and mispredict for four cycles, then mispredict wins
        apply(mk(T_ALU, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1,
                 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("memwait%0d_ctrl", k), ctrl_now(), 16'h0000);
            tick();
            exp_stall = exp_stall + 16'd1;
            check_counters($sformatf("memwait%0d", k));
        end
        d_ready = 1'b1;
        #1;
        chk("memwait_exit_ctrl", ctrl_now(), 16'h000F);
        tick();
        check_counters("memwait_exit");
        idle(1'b1);
        #1;
        chk("memwait_after_ctrl", ctrl_now(), 16'h000C);
        tick();
        exp_inst = exp_inst + 16'd1;
        check_counters("memwait_after");

        // HLT: three drain cycles, then halted held and stall counting stops
        do_reset("halt");
        apply(mk(T_HLT, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0,
                 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0));
        #1;
        chk("hlt_ctrl", ctrl_now(), 16'h0002);
        tick();
        exp_stall = exp_stall + 16'd1;
        idle(1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("drain%0d_ctrl", k), ctrl_now(), 16'h0002);
            tick();
            exp_stall = exp_stall + 16'd1;
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("halted%0d_ctrl", k), ctrl_now(), 16'h0012);
            tick();
        end
        check_counters("halted");

        // Freeze inside DRAIN holds the counter
        do_reset("drainfrz");
        apply(mk(T_HLT, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0,
                 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0));
        tick();
        idle(1'b1);
        tick();
        d_req_mem = 1'b1;
        d_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("drainfrz%0d_ctrl", k), ctrl_now(), 16'h0000);
            tick();
        end
        idle(1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("drainrest%0d_ctrl", k), ctrl_now(), 16'h0002);
            tick();
        end
        #1;
        chk("drainfrz_halted_ctrl", ctrl_now(), 16'h0012);
        exp_stall = 16'd6;
        check_counters("drainfrz");

        // Mispredict right after HLT aborts the drain
        do_reset("abort");
        apply(mk(T_HLT, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0,
                 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0));
        tick();
        exp_stall = exp_stall + 16'd1;
        idle(1'b1);
        valid_ex = 1'b1;
        mispredict_ex = 1'b1;
        #1;
        chk("abort_ctrl", ctrl_now(), 16'h000F);
        tick();
        idle(1'b1);
        #1;
        chk("abort_run_ctrl", ctrl_now(), 16'h000C);
        tick();
        exp_inst = exp_inst + 16'd1;
        check_counters("abort");

        // Count to 16'hFFFF, hold it through a freeze, then wrap on the next issue
        do_reset("wrap");
        idle(1'b1);
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_full", num_inst, 16'hFFFF);
        d_req_mem = 1'b1;
        d_ready = 1'b0;
        tick();
        tick();
        chk("wrap_frozen_hold", num_inst, 16'hFFFF);
        chk("wrap_frozen_stall", stall_cycles, 16'd2);
        d_ready = 1'b1;
        #1;
        chk("wrap_release_ctrl", ctrl_now(), 16'h000C);
        tick();
        chk("wrap_zero", num_inst, 16'h0000);

        // Reset asserted while in MEMWAIT with nonzero counters
        idle(1'b1);
        tick();
        tick();
        d_req_mem = 1'b1;
        d_ready = 1'b0;
        tick();
        tick();
        chk("memwait_pre_reset_ctrl", ctrl_now(), 16'h0000);
        reset = 1'b1;
        #1;
        chk("memwait_reset_ctrl", ctrl_now(), 16'h000C);
        tick();
        reset = 1'b0;
        idle(1'b1);
        chk("memwait_reset_num", num_inst, 16'h0000);
        chk("memwait_reset_stall", stall_cycles, 16'h0000);
        #1;
        chk("post_reset_run_ctrl", ctrl_now(), 16'h000C);
        tick();
        chk("post_reset_issue", num_inst, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
